instruction_fetch: RTL

Pipeline IF stage and the requesting side of the instruction ROM. It drives the word address into the combinational instruction ROM and captures the returned word into the IF/ID pipeline register. It owns the PC and applies stall, branch/jump redirect, self-loop halt detection and misaligned-target fault handling. It sits between the hazard/branch logic (ID/EX) and the ROM.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/if_id_reg.sv | 38 +++
 rtl/instruction_fetch.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch front end.
`default_nettype none

package cpu_pkg;
   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_e;

   localparam word_t NOP_WORD = 32'h0000_0000;
   localparam word_t RESET_PC = 32'h0000_0000;
endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush forces a bubble, hold keeps contents.
`default_nettype none

module if_id_reg
   import cpu_pkg::*;
#(
   parameter word_t BUBBLE = cpu_pkg::NOP_WORD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hold,
   input  logic        flush,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc4_in,
   output logic [31:0] instr,
   output logic [31:0] pc4,
   output logic        valid
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr <= BUBBLE;
         pc4   <= 32'd0;
         valid <= 1'b0;
      end else if (flush) begin
         instr <= BUBBLE;
         pc4   <= 32'd0;
         valid <= 1'b0;
      end else if (!hold) begin
         instr <= instr_in;
         pc4   <= pc4_in;
         valid <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, drives the instruction ROM and fills IF/ID.
`default_nettype none

module instruction_fetch
   import cpu_pkg::*;
#(
   parameter int    ADDR_W   = 6,
   parameter word_t RESET_PC = cpu_pkg::RESET_PC,
   parameter word_t NOP_WORD = cpu_pkg::NOP_WORD
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_dout,
   input  logic              stall,
   input  logic              br_taken,
   input  logic [31:0]       br_target,
   input  logic              jmp,
   input  logic [31:0]       jmp_target,
   output logic [31:0]       if_id_instr,
   output logic [31:0]       if_id_pc4,
   output logic              if_id_valid,
   output logic [31:0]       pc,
   output logic              halted,
   output logic              fault,
   output logic [31:0]       fetch_cnt
);

   fetch_state_e r_state;
   fetch_state_e w_next_state;
   word_t        r_pc;
   word_t        w_next_pc;
   word_t        w_pc_plus4;
   word_t        r_fetch_cnt;
   logic         r_halted;
   logic         r_fault;
   logic         w_flush;
   logic         w_hold;
   logic         w_count;
   logic         w_set_halt;
   logic         w_set_fault;
   logic         w_self_loop;
   logic         w_out_of_range;

   assign w_pc_plus4     = r_pc + 32'd4;
   assign w_self_loop    = if_id_valid && (jmp_target == (if_id_pc4 - 32'd4));
   // Shift form stays legal even when ADDR_W+2 reaches 32.
   assign w_out_of_range = (r_pc >> (ADDR_W + 2)) != 32'd0;

   always_comb begin
      w_next_state = r_state;
      w_next_pc    = r_pc;
      w_flush      = 1'b0;
      w_hold       = 1'b0;
      w_count      = 1'b0;
      w_set_halt   = 1'b0;
      w_set_fault  = 1'b0;
      case (r_state)
         ST_BOOT: begin
            w_next_state = ST_RUN;
            w_flush      = 1'b1;
         end
         ST_RUN: begin
            // EX-stage branch is older than the ID-stage jump, so it wins.
            if (br_taken) begin
               w_flush = 1'b1;
               if (br_target[1:0] != 2'b00) begin
                  w_next_state = ST_FAULT;
                  w_set_fault  = 1'b1;
               end else begin
                  w_next_pc = br_target;
               end
            end else if (jmp) begin
               w_flush = 1'b1;
               if (w_self_loop) begin
                  w_next_state = ST_HALT;
                  w_set_halt   = 1'b1;
               end else if (jmp_target[1:0] != 2'b00) begin
                  w_next_state = ST_FAULT;
                  w_set_fault  = 1'b1;
               end else begin
                  w_next_pc = jmp_target;
               end
            end else if (stall) begin
               w_hold = 1'b1;
            end else if (w_out_of_range) begin
               w_next_state = ST_FAULT;
               w_set_fault  = 1'b1;
               w_flush      = 1'b1;
            end else begin
               w_next_pc = w_pc_plus4;
               w_count   = 1'b1;
            end
         end
         default: begin
            w_flush = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_BOOT;
         r_pc        <= RESET_PC;
         r_halted    <= 1'b0;
         r_fault     <= 1'b0;
         r_fetch_cnt <= 32'd0;
      end else begin
         r_state <= w_next_state;
         r_pc    <= w_next_pc;
         if (w_set_halt)  r_halted    <= 1'b1;
         if (w_set_fault) r_fault     <= 1'b1;
         if (w_count)     r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
   end

   if_id_reg #(
      .BUBBLE(NOP_WORD)
   ) u_if_id_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .hold     (w_hold),
      .flush    (w_flush),
      .instr_in (rom_dout),
      .pc4_in   (w_pc_plus4),
      .instr    (if_id_instr),
      .pc4      (if_id_pc4),
      .valid    (if_id_valid)
   );

   assign rom_addr  = r_pc[ADDR_W+1:2];
   assign pc        = r_pc;
   assign halted    = r_halted;
   assign fault     = r_fault;
   assign fetch_cnt = r_fetch_cnt;

endmodule

`default_nettype wire
